ecc_81_err_stat: RTL and testbench
==================================

Name: ecc_81_err_stat

Overview:
Downstream stage of the 81-bit ECC fault-detect/correct path on the FIFO read side.
- Registers corrected read data with a valid/ready handshake.
- Keeps saturating counters of single-bit, double-bit and checker-fault events.
- Captures address and type of the first error since the last clear.
- Raises a sticky interrupt to the status/CSR block.

Parameters:
DATA_WIDTH, 81, width of corrected data word
ADDR_WIDTH, 8, width of FIFO read address carried with each word
CNT_WIDTH, 16, width of each saturating error counter
SBIT_THRESH, 16'd255, sbit_cnt value at which a single-bit interrupt is raised (no interrupt when 0)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_vld  input  1  read word valid from ECC fault-detect stage
in_rdy  output  1  this stage can accept a word
in_addr  input  ADDR_WIDTH  FIFO address of the word
in_data  input  DATA_WIDTH  corrected data from ECC fault-detect stage
in_sbit_err  input  1  single-bit error flag
in_dbit_err  input  1  double-bit error flag
in_ecc_fault  input  1  dual-checker mismatch flag
out_vld  output  1  registered word valid
out_rdy  input  1  consumer ready
out_data  output  DATA_WIDTH  registered data
out_dbit_err  output  1  registered dbit flag, so the consumer can drop the word
stat_clr  input  1  synchronous clear of counters, capture and irq (1-cycle pulse)
sbit_cnt  output  CNT_WIDTH  accepted words with sbit_err=1
dbit_cnt  output  CNT_WIDTH  accepted words with dbit_err=1
fault_cnt  output  CNT_WIDTH  accepted words with ecc_fault=1
first_err_addr  output  ADDR_WIDTH  address of first error since clear
first_err_type  output  2  error type: 00 none, 01 sbit, 10 dbit, 11 fault
err_irq  output  1  sticky interrupt

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, capture FSM in IDLE, data register 0.
- Accept condition: in_vld & in_rdy. Output-side handshake completes on out_vld & out_rdy.
- Data path, base build: one register stage, latency 1 cycle.
  - in_rdy = ~out_vld | out_rdy (combinational from out_rdy).
  - out_vld set on accept; cleared on output handshake without a new accept.
  - out_data and out_dbit_err stay stable while out_vld & ~out_rdy.
- Event type of an accepted word, fault > dbit > sbit priority:
  - 11 if in_ecc_fault
  - else 10 if in_dbit_err
  - else 01 if in_sbit_err
  - else none.
- Counters: each increments by 1 when its flag is set on an accepted word, independently, so one word may bump several counters.
  - Saturate at all-ones; never wrap.
  - Flags are ignored unless the word is accepted.
- Capture FSM, two states:
  - IDLE: on an accepted word with type != 00, load first_err_addr and first_err_type, then go to LOCKED.
  - LOCKED: hold values, ignore later errors.
  - stat_clr in any state: go to IDLE and zero the capture.
- err_irq set (sticky) on any of:
  - an accepted word with dbit or fault
  - sbit_cnt transitioning to SBIT_THRESH (only when SBIT_THRESH != 0).
  - Cleared only by stat_clr or reset.
- stat_clr in the same cycle as an accepted error word:
  - Clear applies first, then the event is applied.
  - Affected counters read 1, the capture holds the new word (state LOCKED), err_irq reflects the new word only.
- stat_clr does not affect the data path or the handshake.
- Reset mid-transfer drops any held word; out_vld goes 0 immediately.

Optional Feature:
ECC_STAT_SKID_EN
- Defined: a 2-entry skid buffer replaces the single register.
  - in_rdy is a register output: high when fewer than 2 entries are held.
  - No combinational path from out_rdy to in_rdy.
  - Latency stays 1 cycle when empty; order is preserved.
  - Full throughput under continuous out_rdy.
- Undefined: single register as described in Behaviour.
- Counters, capture and irq behave identically in both builds.

Test Plan:
- Reset then 10 clean words with out_rdy=1 → out_data matches inputs 1 cycle later; all counters 0, first_err_type=00, err_irq=0.
- Word at addr 8'h12 with sbit, then addr 8'h34 with dbit → sbit_cnt=1, dbit_cnt=1, first_err_addr=8'h12, type=01, err_irq=1 after the dbit word.
- Single word with fault+dbit+sbit → all three counters 1, type=11.
- Hold out_rdy=0 for 5 cycles with in_vld=1 → base build: out_data stable, only 1 word accepted, counters count once. ECC_STAT_SKID_EN build: exactly 2 words accepted.
- With CNT_WIDTH=4 and SBIT_THRESH=3, drive 20 sbit words → err_irq rises on the 3rd; sbit_cnt saturates at 4'hF.
- stat_clr coincident with an sbit word at addr 8'h56 → sbit_cnt=1, first_err_addr=8'h56, earlier capture gone; assert rst_n low mid-stream → out_vld=0 and counters 0 asynchronously.

Source files
------------

// File: rtl/ecc_81_err_stat.sv
// ecc_81_err_stat: output stage of the 81-bit ECC read path.
// Registers corrected data with a valid/ready handshake and keeps error statistics:
// saturating counters, first-error capture and a sticky interrupt.
// Build option: define ECC_STAT_SKID_EN to replace the single output register with a
// 2-entry skid buffer that has a registered in_rdy.
module ecc_81_err_stat #(
    parameter int unsigned DATA_WIDTH  = 81,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SBIT_THRESH = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic                  in_ecc_fault,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_dbit_err,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [1:0]            first_err_type,
    output logic                  err_irq
);

    localparam logic [CNT_WIDTH-1:0] LpThresh = CNT_WIDTH'(SBIT_THRESH);

    typedef enum logic {StIdle, StLocked} cap_state_e;

    logic w_accept;
    assign w_accept = in_vld & in_rdy;

`ifdef ECC_STAT_SKID_EN
    logic [1:0]                 r_cnt;
    logic [1:0]                 w_cnt_next;
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic                       r_in_rdy;
    logic [1:0][DATA_WIDTH-1:0] r_mem_data;
    logic [1:0]                 r_mem_dbit;
    logic                       w_pop;

    assign in_rdy       = r_in_rdy;
    assign out_vld      = (r_cnt != 2'd0);
    assign out_data     = r_mem_data[r_rd_ptr];
    assign out_dbit_err = r_mem_dbit[r_rd_ptr];
    assign w_pop        = out_vld & out_rdy;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_cnt_next = r_cnt + {1'b0, w_accept} - {1'b0, w_pop};
    end

    // Two-entry FIFO; in_rdy registered from next occupancy so out_rdy never reaches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_mem_data <= '0;
            r_mem_dbit <= '0;
        end else begin
            if (w_accept) begin
                r_mem_data[r_wr_ptr] <= in_data;
                r_mem_dbit[r_wr_ptr] <= in_dbit_err;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt    <= w_cnt_next;
            r_in_rdy <= (w_cnt_next != 2'd2);
        end
    end
`else
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_dbit;

    assign in_rdy       = ~r_vld | out_rdy;
    assign out_vld      = r_vld;
    assign out_data     = r_data;
    assign out_dbit_err = r_dbit;

    // Single pipeline register; data held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_dbit <= 1'b0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_data <= in_data;
            r_dbit <= in_dbit_err;
        end else if (out_rdy) begin
            r_vld <= 1'b0;
        end
    end
`endif

    logic [CNT_WIDTH-1:0]  r_sbit_cnt, r_dbit_cnt, r_fault_cnt;
    logic [CNT_WIDTH-1:0]  w_sbit_base, w_dbit_base, w_fault_base;
    logic [CNT_WIDTH-1:0]  w_sbit_next, w_dbit_next, w_fault_next;
    logic                  r_irq, w_irq_next, w_sbit_hit;
    logic [1:0]            w_type;
    cap_state_e            r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_cap_addr, w_cap_addr_next;
    logic [1:0]            r_cap_type, w_cap_type_next;

    assign sbit_cnt       = r_sbit_cnt;
    assign dbit_cnt       = r_dbit_cnt;
    assign fault_cnt      = r_fault_cnt;
    assign err_irq        = r_irq;
    assign first_err_addr = r_cap_addr;
    assign first_err_type = r_cap_type;

    // Event classification, fault > dbit > sbit
    always_comb begin
        w_type = 2'b00;
        if (in_ecc_fault)     w_type = 2'b11;
        else if (in_dbit_err) w_type = 2'b10;
        else if (in_sbit_err) w_type = 2'b01;
    end

    // Counter and irq next state; a clear is applied before the same-cycle event
    always_comb begin
        w_sbit_base  = stat_clr ? '0 : r_sbit_cnt;
        w_dbit_base  = stat_clr ? '0 : r_dbit_cnt;
        w_fault_base = stat_clr ? '0 : r_fault_cnt;
        w_sbit_next  = w_sbit_base;
        w_dbit_next  = w_dbit_base;
        w_fault_next = w_fault_base;
        if (w_accept && in_sbit_err && (w_sbit_base != '1)) begin
            w_sbit_next = w_sbit_base + CNT_WIDTH'(1);
        end
        if (w_accept && in_dbit_err && (w_dbit_base != '1)) begin
            w_dbit_next = w_dbit_base + CNT_WIDTH'(1);
        end
        if (w_accept && in_ecc_fault && (w_fault_base != '1)) begin
            w_fault_next = w_fault_base + CNT_WIDTH'(1);
        end
        // Fire only on the step onto the threshold, not while parked there
        w_sbit_hit = (SBIT_THRESH != 0) && (w_sbit_next == LpThresh) &&
                     (w_sbit_next != w_sbit_base);
        w_irq_next = (stat_clr ? 1'b0 : r_irq) |
                     (w_accept & (in_dbit_err | in_ecc_fault)) | w_sbit_hit;
    end

    // Capture FSM next state: clear first, then a first error in IDLE locks the capture
    always_comb begin
        w_state_next    = stat_clr ? StIdle : r_state;
        w_cap_addr_next = stat_clr ? '0 : r_cap_addr;
        w_cap_type_next = stat_clr ? 2'b00 : r_cap_type;
        if ((w_state_next == StIdle) && w_accept && (w_type != 2'b00)) begin
            w_state_next    = StLocked;
            w_cap_addr_next = in_addr;
            w_cap_type_next = w_type;
        end
    end

    // Statistics state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbit_cnt  <= '0;
            r_dbit_cnt  <= '0;
            r_fault_cnt <= '0;
            r_irq       <= 1'b0;
            r_state     <= StIdle;
            r_cap_addr  <= '0;
            r_cap_type  <= 2'b00;
        end else begin
            r_sbit_cnt  <= w_sbit_next;
            r_dbit_cnt  <= w_dbit_next;
            r_fault_cnt <= w_fault_next;
            r_irq       <= w_irq_next;
            r_state     <= w_state_next;
            r_cap_addr  <= w_cap_addr_next;
            r_cap_type  <= w_cap_type_next;
        end
    end

endmodule

// File: tb/tb_ecc_81_err_stat.sv
// Randomized bench for ecc_81_err_stat against a queue-based reference model.
// Two instances share stimulus: default parameters and CNT_WIDTH=4 / SBIT_THRESH=3.
module tb_ecc_81_err_stat;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic [7:0]  in_addr = '0;
    logic [80:0] in_data = '0;
    logic        in_sbit_err = 1'b0;
    logic        in_dbit_err = 1'b0;
    logic        in_ecc_fault = 1'b0;
    logic        out_rdy = 1'b0;
    logic        stat_clr = 1'b0;

    logic        in_rdy, out_vld, out_dbit_err, err_irq;
    logic [80:0] out_data;
    logic [15:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic [7:0]  first_err_addr;
    logic [1:0]  first_err_type;

    logic        s_in_rdy, s_out_vld, s_out_dbit_err, s_err_irq;
    logic [80:0] s_out_data;
    logic [3:0]  s_sbit_cnt, s_dbit_cnt, s_fault_cnt;
    logic [7:0]  s_first_err_addr;
    logic [1:0]  s_first_err_type;

    always #5 clk = ~clk;

    ecc_81_err_stat u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr),
        .in_data(in_data), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
        .in_ecc_fault(in_ecc_fault), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .out_dbit_err(out_dbit_err), .stat_clr(stat_clr),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
        .first_err_addr(first_err_addr), .first_err_type(first_err_type), .err_irq(err_irq)
    );

    ecc_81_err_stat #(.CNT_WIDTH(4), .SBIT_THRESH(3)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(s_in_rdy), .in_addr(in_addr),
        .in_data(in_data), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
        .in_ecc_fault(in_ecc_fault), .out_vld(s_out_vld), .out_rdy(out_rdy),
        .out_data(s_out_data), .out_dbit_err(s_out_dbit_err), .stat_clr(stat_clr),
        .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt), .fault_cnt(s_fault_cnt),
        .first_err_addr(s_first_err_addr), .first_err_type(s_first_err_type),
        .err_irq(s_err_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: words in flight, per-instance counters, capture and irq
    typedef struct {
        logic [80:0] data;
        logic        dbit;
    } word_t;
    word_t q[$];
    int    cnt_max[2] = '{65535, 15};
    int    thresh[2]  = '{255, 3};
    int    sb_m[2], db_m[2], ft_m[2];
    bit    irq_m[2];
    int    cap_type_m;
    int    cap_addr_m;
    int    n_acc;
    logic  obs_irq_small;

    function automatic logic [80:0] rand81();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[80:0];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 2; i++) begin
            sb_m[i] = 0; db_m[i] = 0; ft_m[i] = 0; irq_m[i] = 1'b0;
        end
        cap_type_m = 0;
        cap_addr_m = 0;
    endtask

    task automatic check_outputs();
        chk("out_vld", out_vld, q.size() != 0);
        chk("s_out_vld", s_out_vld, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_dbit", out_dbit_err, q[0].dbit);
            chk("s_out_data", s_out_data, q[0].data);
        end
        chk("sbit_cnt", sbit_cnt, sb_m[0]);
        chk("dbit_cnt", dbit_cnt, db_m[0]);
        chk("fault_cnt", fault_cnt, ft_m[0]);
        chk("err_irq", err_irq, irq_m[0]);
        chk("s_sbit_cnt", s_sbit_cnt, sb_m[1]);
        chk("s_dbit_cnt", s_dbit_cnt, db_m[1]);
        chk("s_fault_cnt", s_fault_cnt, ft_m[1]);
        chk("s_err_irq", s_err_irq, irq_m[1]);
        chk("first_type", first_err_type, cap_type_m);
        chk("first_addr", first_err_addr, cap_addr_m);
        chk("s_first_type", s_first_err_type, cap_type_m);
        chk("s_first_addr", s_first_err_addr, cap_addr_m);
    endtask

    // One clock cycle: drive, check state from the previous edge, advance the model
    task automatic step(input logic vld, input logic ordy, input logic clr, input logic s,
                        input logic d, input logic f, input logic [7:0] addr);
        bit rdy_m, acc, pop;
        int old, t;
        @(negedge clk);
        in_vld = vld; out_rdy = ordy; stat_clr = clr; in_addr = addr;
        in_sbit_err = s; in_dbit_err = d; in_ecc_fault = f; in_data = rand81();
        #1;
        check_outputs();
        obs_irq_small = s_err_irq;
`ifdef ECC_STAT_SKID_EN
        rdy_m = (q.size() < 2);
`else
        rdy_m = (q.size() == 0) || ordy;
`endif
        chk("in_rdy", in_rdy, rdy_m);
        chk("s_in_rdy", s_in_rdy, rdy_m);
        if (vld && in_rdy) n_acc++;
        acc = vld && rdy_m;
        pop = (q.size() != 0) && ordy;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{data: in_data, dbit: d});
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                sb_m[i] = 0; db_m[i] = 0; ft_m[i] = 0; irq_m[i] = 1'b0;
            end
            if (acc) begin
                if (s) begin
                    old = sb_m[i];
                    if (sb_m[i] < cnt_max[i]) sb_m[i]++;
                    if (thresh[i] != 0 && sb_m[i] == thresh[i] && old != thresh[i])
                        irq_m[i] = 1'b1;
                end
                if (d && db_m[i] < cnt_max[i]) db_m[i]++;
                if (f && ft_m[i] < cnt_max[i]) ft_m[i]++;
                if (d || f) irq_m[i] = 1'b1;
            end
        end
        if (clr) begin
            cap_type_m = 0;
            cap_addr_m = 0;
        end
        if (acc && cap_type_m == 0) begin
            t = f ? 3 : d ? 2 : s ? 1 : 0;
            if (t != 0) begin
                cap_type_m = t;
                cap_addr_m = addr;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, ordy, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int base, exp_acc;
        model_reset();
        n_acc = 0;
        #12;
        // Reset state
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_out_data", out_data, 81'd0);
        chk("rst_sbit", sbit_cnt, 16'd0);
        chk("rst_irq", err_irq, 1'b0);
        chk("rst_type", first_err_type, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Ten clean words at full throughput
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i));
        idle(1'b1);
        chk("clean_type", first_err_type, 2'b00);
        chk("clean_irq", err_irq, 1'b0);

        // sbit at 0x12, then dbit at 0x34
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12);
        idle(1'b1);
        chk("sbit_only_irq", err_irq, 1'b0);
        chk("sbit_only_cnt", sbit_cnt, 16'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h34);
        idle(1'b1);
        chk("seq_sbit", sbit_cnt, 16'd1);
        chk("seq_dbit", dbit_cnt, 16'd1);
        chk("seq_addr", first_err_addr, 8'h12);
        chk("seq_type", first_err_type, 2'b01);
        chk("seq_irq", err_irq, 1'b1);

        // All three flags on one word after a clear
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        idle(1'b1);
        chk("all_sbit", sbit_cnt, 16'd1);
        chk("all_dbit", dbit_cnt, 16'd1);
        chk("all_fault", fault_cnt, 16'd1);
        chk("all_type", first_err_type, 2'b11);

        // Stall: out_rdy low for five cycles with in_vld high
        idle(1'b1);
        base = sbit_cnt;
        n_acc = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
`ifdef ECC_STAT_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        chk("stall_acc", n_acc, exp_acc);
        idle(1'b0);
        chk("stall_cnt", sbit_cnt, 16'(base + exp_acc));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Saturation and threshold on the small instance
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h80 + k));
            if (k == 2) chk("thr_before", obs_irq_small, 1'b0);
            if (k == 3) chk("thr_at3", obs_irq_small, 1'b1);
        end
        idle(1'b1);
        chk("sat_small", s_sbit_cnt, 4'hF);
        chk("sat_big", sbit_cnt, 16'd20);

        // Clear coincident with an sbit word at 0x56
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h56);
        idle(1'b1);
        chk("clr_sbit", sbit_cnt, 16'd1);
        chk("clr_addr", first_err_addr, 8'h56);
        chk("clr_type", first_err_type, 2'b01);
        chk("clr_irq", s_err_irq, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(9) < 7), ($urandom_range(9) < 7), ($urandom_range(29) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(6) == 0), ($urandom_range(9) == 0),
                 8'($urandom()));
        end

        // Reset mid-stream with a held word and nonzero counters
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        idle(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_vld, 1'b0);
        chk("mid_rst_sbit", sbit_cnt, 16'd0);
        chk("mid_rst_irq", err_irq, 1'b0);
        chk("mid_rst_type", first_err_type, 2'b00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(1) == 1), ($urandom_range(3) != 0), 1'b0,
                 ($urandom_range(3) == 0), ($urandom_range(7) == 0), 1'b0, 8'($urandom()));
        end
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
